// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: request-edge register file initiator with operand read FSM,
// arbitrated write-back FSM and a 32-entry busy scoreboard for RAW/WAW locking.
module regfile_access_ctrl #(
    parameter int DataWidth   = 32,
    parameter bit LsuPriority = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 iss_valid_i,
    output logic                 iss_ready_o,
    input  logic [4:0]           iss_rs1_i,
    input  logic [4:0]           iss_rs2_i,
    input  logic [4:0]           iss_rd_i,
    input  logic                 iss_rd_we_i,
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    output logic [DataWidth-1:0] op_a_o,
    output logic [DataWidth-1:0] op_b_o,
    input  logic                 alu_wb_valid_i,
    output logic                 alu_wb_ready_o,
    input  logic [4:0]           alu_wb_addr_i,
    input  logic                 lsu_wb_valid_i,
    output logic                 lsu_wb_ready_o,
    input  logic [4:0]           lsu_wb_addr_i,
    output logic                 req_ra_o,
    output logic                 req_rb_o,
    output logic [4:0]           raddr_a_o,
    output logic [4:0]           raddr_b_o,
    input  logic [DataWidth-1:0] rdata_a_i,
    input  logic [DataWidth-1:0] rdata_b_i,
    output logic                 req_w_o,
    output logic [4:0]           waddr_o,
    output logic                 soursel_o,
    output logic [31:0]          busy_o
);
    typedef enum logic [2:0] {RD_IDLE, RD_SETUP, RD_STROBE, RD_CAPTURE, RD_HOLD} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_STROBE} wr_state_e;

    rd_state_e            rd_state_q, rd_state_d;
    wr_state_e            wr_state_q, wr_state_d;
    logic [31:0]          busy_q, busy_d;
    logic [4:0]           raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d;
    logic                 req_r_q, req_r_d;
    logic                 op_valid_q, op_valid_d;
    logic [DataWidth-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [4:0]           waddr_q, waddr_d;
    logic                 soursel_q, soursel_d;
    logic                 req_w_q, req_w_d;
    logic                 alu_rdy_q, alu_rdy_d, lsu_rdy_q, lsu_rdy_d;
    logic                 live_q;
    logic                 hazard, iss_fire, lsu_first, wb_any;

    // Hazards are judged against the registered scoreboard, so a same-cycle clear is seen next cycle
    assign hazard = (busy_q[iss_rs1_i] && iss_rs1_i != 5'd0)
                 || (busy_q[iss_rs2_i] && iss_rs2_i != 5'd0)
                 || (iss_rd_we_i && busy_q[iss_rd_i] && iss_rd_i != 5'd0);
    assign iss_ready_o = live_q && rd_state_q == RD_IDLE && !hazard;
    assign iss_fire    = iss_valid_i && iss_ready_o;
    assign lsu_first   = lsu_wb_valid_i && (LsuPriority || !alu_wb_valid_i);
    // A source still sees its ready pulse this cycle; skip arbitration so it is not granted twice
    assign wb_any      = (alu_wb_valid_i || lsu_wb_valid_i) && !alu_rdy_q && !lsu_rdy_q;

    always_comb begin
        rd_state_d = rd_state_q;
        raddr_a_d  = raddr_a_q;
        raddr_b_d  = raddr_b_q;
        req_r_d    = 1'b0;
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        case (rd_state_q)
            RD_IDLE: if (iss_fire) begin
                raddr_a_d  = iss_rs1_i;
                raddr_b_d  = iss_rs2_i;
                rd_state_d = RD_SETUP;
            end
            RD_SETUP: begin
                req_r_d    = 1'b1;
                rd_state_d = RD_STROBE;
            end
            RD_STROBE: begin
                op_a_d     = raddr_a_q == 5'd0 ? '0 : rdata_a_i;
                op_b_d     = raddr_b_q == 5'd0 ? '0 : rdata_b_i;
                op_valid_d = 1'b1;
                rd_state_d = RD_CAPTURE;
            end
            RD_CAPTURE, RD_HOLD: begin
                op_valid_d = !op_ready_i;
                rd_state_d = op_ready_i ? RD_IDLE : RD_HOLD;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        soursel_d  = soursel_q;
        req_w_d    = 1'b0;
        alu_rdy_d  = 1'b0;
        lsu_rdy_d  = 1'b0;
        case (wr_state_q)
            WR_IDLE: if (wb_any) begin
                alu_rdy_d  = !lsu_first;
                lsu_rdy_d  = lsu_first;
                waddr_d    = lsu_first ? lsu_wb_addr_i : alu_wb_addr_i;
                soursel_d  = !lsu_first;
                wr_state_d = waddr_d == 5'd0 ? WR_IDLE : WR_SETUP;
            end
            WR_SETUP: begin
                req_w_d    = 1'b1;
                wr_state_d = WR_STROBE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (wr_state_q == WR_STROBE) busy_d[waddr_q] = 1'b0;
        if (iss_fire && iss_rd_we_i && iss_rd_i != 5'd0) busy_d[iss_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            busy_q     <= '0;
            raddr_a_q  <= '0;
            raddr_b_q  <= '0;
            req_r_q    <= 1'b0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            waddr_q    <= '0;
            soursel_q  <= 1'b0;
            req_w_q    <= 1'b0;
            alu_rdy_q  <= 1'b0;
            lsu_rdy_q  <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            busy_q     <= busy_d;
            raddr_a_q  <= raddr_a_d;
            raddr_b_q  <= raddr_b_d;
            req_r_q    <= req_r_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            waddr_q    <= waddr_d;
            soursel_q  <= soursel_d;
            req_w_q    <= req_w_d;
            alu_rdy_q  <= alu_rdy_d;
            lsu_rdy_q  <= lsu_rdy_d;
            live_q     <= 1'b1;
        end
    end

    assign op_valid_o     = op_valid_q;
    assign op_a_o         = op_a_q;
    assign op_b_o         = op_b_q;
    assign req_ra_o       = req_r_q;
    assign req_rb_o       = req_r_q;
    assign raddr_a_o      = raddr_a_q;
    assign raddr_b_o      = raddr_b_q;
    assign req_w_o        = req_w_q;
    assign waddr_o        = waddr_q;
    assign soursel_o      = soursel_q;
    assign alu_wb_ready_o = alu_rdy_q;
    assign lsu_wb_ready_o = lsu_rdy_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: scoreboard bench with a behavioural register file; a second
// instance with ALU priority checks the reversed arbitration order.
module tb_regfile_access_ctrl;
    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
    logic        iss_valid = 1'b0, iss_we = 1'b0, op_ready = 1'b1;
    logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic        alu_v = 1'b0, lsu_v = 1'b0;
    logic [4:0]  alu_addr = '0, lsu_addr = '0;
    logic [31:0] alu_wdata = '0, lsu_wdata = '0;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_a = '0;
    logic [31:0] pl_d = '0;
    logic [31:0] mem [32];
    int          cyc = 0, cmps = 0, errs = 0;
    logic [63:0] opq [$];
    logic [37:0] wq0 [$], wq1 [$];

    logic        iss_ready, op_valid, alu_rdy0, lsu_rdy0, req_ra, req_rb, req_w, soursel;
    logic [31:0] op_a, op_b, rdata_a, rdata_b, busy;
    logic [4:0]  raddr_a, raddr_b, waddr;
    logic        iss_ready1, op_valid1, alu_rdy1, lsu_rdy1, req_ra1, req_rb1, req_w1, soursel1;
    logic [31:0] op_a1, op_b1, busy1;
    logic [4:0]  raddr_a1, raddr_b1, waddr1;
    logic        alu_v0, lsu_v0, alu_v1, lsu_v1, alu_rdy, lsu_rdy;
    logic        zero1 = 1'b0, one1 = 1'b1;
    logic [4:0]  zero5 = '0;
    logic [31:0] zero32 = '0;

    assign alu_v0  = alu_v && !sel;
    assign lsu_v0  = lsu_v && !sel;
    assign alu_v1  = alu_v && sel;
    assign lsu_v1  = lsu_v && sel;
    assign alu_rdy = sel ? alu_rdy1 : alu_rdy0;
    assign lsu_rdy = sel ? lsu_rdy1 : lsu_rdy0;
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

    regfile_access_ctrl #(.DataWidth(32), .LsuPriority(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .iss_valid_i(iss_valid), .iss_ready_o(iss_ready),
        .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2), .iss_rd_i(iss_rd), .iss_rd_we_i(iss_we),
        .op_valid_o(op_valid), .op_ready_i(op_ready), .op_a_o(op_a), .op_b_o(op_b),
        .alu_wb_valid_i(alu_v0), .alu_wb_ready_o(alu_rdy0), .alu_wb_addr_i(alu_addr),
        .lsu_wb_valid_i(lsu_v0), .lsu_wb_ready_o(lsu_rdy0), .lsu_wb_addr_i(lsu_addr),
        .req_ra_o(req_ra), .req_rb_o(req_rb), .raddr_a_o(raddr_a), .raddr_b_o(raddr_b),
        .rdata_a_i(rdata_a), .rdata_b_i(rdata_b), .req_w_o(req_w), .waddr_o(waddr),
        .soursel_o(soursel), .busy_o(busy));

    regfile_access_ctrl #(.DataWidth(32), .LsuPriority(1'b0)) dut_alu (
        .clk_i(clk), .rst_i(rst), .iss_valid_i(zero1), .iss_ready_o(iss_ready1),
        .iss_rs1_i(zero5), .iss_rs2_i(zero5), .iss_rd_i(zero5), .iss_rd_we_i(zero1),
        .op_valid_o(op_valid1), .op_ready_i(one1), .op_a_o(op_a1), .op_b_o(op_b1),
        .alu_wb_valid_i(alu_v1), .alu_wb_ready_o(alu_rdy1), .alu_wb_addr_i(alu_addr),
        .lsu_wb_valid_i(lsu_v1), .lsu_wb_ready_o(lsu_rdy1), .lsu_wb_addr_i(lsu_addr),
        .req_ra_o(req_ra1), .req_rb_o(req_rb1), .raddr_a_o(raddr_a1), .raddr_b_o(raddr_b1),
        .rdata_a_i(zero32), .rdata_b_i(zero32), .req_w_o(req_w1), .waddr_o(waddr1),
        .soursel_o(soursel1), .busy_o(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (req_w) mem[waddr] <= soursel ? alu_wdata : lsu_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && op_valid && op_ready) begin
            chk("op_expected", 64'(opq.size() > 0), 64'd1);
            if (opq.size() > 0) chk("op_data", {op_a, op_b}, opq.pop_front());
        end
        if (!rst && req_w) begin
            chk("wr_expected", 64'(wq0.size() > 0), 64'd1);
            if (wq0.size() > 0)
                chk("wr_lsu_pri", {26'd0, waddr, soursel, soursel ? alu_wdata : lsu_wdata}, {26'd0, wq0.pop_front()});
        end
        if (!rst && req_w1) begin
            chk("wr1_expected", 64'(wq1.size() > 0), 64'd1);
            if (wq1.size() > 0)
                chk("wr_alu_pri", {26'd0, waddr1, soursel1, soursel1 ? alu_wdata : lsu_wdata}, {26'd0, wq1.pop_front()});
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic we, input logic [31:0] ea, input logic [31:0] eb);
        int n = 0;
        @(posedge clk); #1;
        iss_rs1 = a; iss_rs2 = b; iss_rd = d; iss_we = we; iss_valid = 1'b1;
        opq.push_back({ea, eb});
        @(negedge clk);
        while (!iss_ready && n < 60) begin n++; @(negedge clk); end
        chk("iss_accept", 64'(iss_ready), 64'd1);
        @(posedge clk); #1;
        iss_valid = 1'b0;
    endtask

    task automatic wb(input logic lsu, input logic [4:0] ad, input logic [31:0] dt, output int t);
        int n = 0;
        @(posedge clk); #1;
        if (lsu) begin lsu_v = 1'b1; lsu_addr = ad; lsu_wdata = dt; end
        else begin alu_v = 1'b1; alu_addr = ad; alu_wdata = dt; end
        @(negedge clk);
        while (!(lsu ? lsu_rdy : alu_rdy) && n < 60) begin n++; @(negedge clk); end
        chk(lsu ? "lsu_grant" : "alu_grant", 64'(lsu ? lsu_rdy : alu_rdy), 64'd1);
        t = cyc;
        @(posedge clk); #1;
        if (lsu) lsu_v = 1'b0; else alu_v = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tl, n;
        preload(5'd0, 32'hBAD0_BAD0);
        preload(5'd1, 32'h0000_0011);
        preload(5'd2, 32'h0000_0022);
        preload(5'd5, 32'hDEAD_BEEF);
        preload(5'd6, 32'h1234_5678);
        preload(5'd7, 32'h0000_0000);
        @(negedge clk);
        chk("rst_iss_ready", 64'(iss_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", {61'd0, req_ra, req_rb, req_w}, 64'd0);
        chk("rst_op", {31'd0, op_valid, op_a}, 64'd0);
        chk("rst_wb_ready", {62'd0, alu_rdy0, lsu_rdy0}, 64'd0);
        chk("rst_addr", {53'd0, raddr_a, raddr_b, waddr, soursel}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(iss_ready), 64'd1);

        // basic read with strobe timing
        issue(5'd5, 5'd6, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        chk("c1_strobe_low", {62'd0, req_ra, req_rb}, 64'd0);
        chk("c1_addr", {54'd0, raddr_a, raddr_b}, {54'd0, 5'd5, 5'd6});
        chk("c1_iss_ready", 64'(iss_ready), 64'd0);
        @(negedge clk);
        chk("c2_strobe", {62'd0, req_ra, req_rb}, 64'd3);
        chk("c2_addr", {54'd0, raddr_a, raddr_b}, {54'd0, 5'd5, 5'd6});
        @(negedge clk);
        chk("c3_op_valid", 64'(op_valid), 64'd1);

        issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);

        // RAW lock on x7
        issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h11, 32'h22);
        chk("busy_set", 64'(busy), 64'h80);
        wq0.push_back({5'd7, 1'b1, 32'hA5A5_A5A5});
        fork
            issue(5'd7, 5'd2, 5'd0, 1'b0, 32'hA5A5_A5A5, 32'h22);
            begin
                @(posedge clk); @(negedge clk);
                chk("raw_stall", 64'(iss_ready), 64'd0);
                wb(1'b0, 5'd7, 32'hA5A5_A5A5, ta);
            end
        join
        repeat (3) @(negedge clk);
        chk("busy_clear", 64'(busy), 64'd0);

        // x0 write-back: accepted, no strobe, scoreboard untouched
        issue(5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 32'd0);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF, tl);
        repeat (3) @(negedge clk);
        chk("x0_wb_busy", 64'(busy), 64'h200);
        wq0.push_back({5'd9, 1'b1, 32'h99});
        wb(1'b0, 5'd9, 32'h99, ta);
        @(negedge clk);
        chk("x9_busy_clear", 64'(busy), 64'd0);

        // arbitration, LSU priority
        wq0.push_back({5'd4, 1'b0, 32'h44});
        wq0.push_back({5'd3, 1'b1, 32'h33});
        fork
            wb(1'b0, 5'd3, 32'h33, ta);
            wb(1'b1, 5'd4, 32'h44, tl);
        join
        chk("lsu_pri_gap", 64'(ta - tl), 64'd3);
        issue(5'd3, 5'd4, 5'd0, 1'b0, 32'h33, 32'h44);

        // arbitration, ALU priority instance
        repeat (4) @(posedge clk);
        sel = 1'b1;
        wq1.push_back({5'd3, 1'b1, 32'h133});
        wq1.push_back({5'd4, 1'b0, 32'h144});
        fork
            wb(1'b0, 5'd3, 32'h133, ta);
            wb(1'b1, 5'd4, 32'h144, tl);
        join
        chk("alu_pri_gap", 64'(tl - ta), 64'd3);
        repeat (2) @(posedge clk);
        sel = 1'b0;

        // backpressure with a concurrent write-back
        op_ready = 1'b0;
        wq0.push_back({5'd8, 1'b1, 32'h88});
        issue(5'd5, 5'd6, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        fork
            wb(1'b0, 5'd8, 32'h88, ta);
            begin
                n = 0;
                @(negedge clk);
                while (!op_valid && n < 20) begin n++; @(negedge clk); end
                repeat (5) begin
                    chk("bp_hold", {op_valid, iss_ready, op_a, op_b[29:0]}, {1'b1, 1'b0, 32'hDEAD_BEEF, 30'h1234_5678});
                    @(negedge clk);
                end
            end
        join
        @(posedge clk); #1;
        op_ready = 1'b1;
        repeat (2) @(posedge clk);
        issue(5'd8, 5'd0, 5'd0, 1'b0, 32'h88, 32'd0);
        repeat (4) @(posedge clk);

        // reset in the middle of the read strobe
        @(posedge clk); #1;
        iss_rs1 = 5'd5; iss_rs2 = 5'd6; iss_rd = 5'd10; iss_we = 1'b1; iss_valid = 1'b1;
        @(negedge clk);
        chk("mid_accept", 64'(iss_ready), 64'd1);
        @(posedge clk); #1;
        iss_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_strobe", {62'd0, req_ra, req_rb}, 64'd3);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_strobes", {61'd0, req_ra, req_rb, req_w}, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_state", {62'd0, iss_ready, op_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", 64'(iss_ready), 64'd1);
        repeat (4) @(negedge clk);
        chk("queues_empty", 64'(opq.size() + wq0.size() + wq1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
